// File: rtl/color_pkg.sv
// Shared types for the colour sequencer: hue segment encoding, channel indices
// and the segment stepping helper.
package color_pkg;

    typedef enum logic [2:0] {
        SEG_RY = 3'd0,
        SEG_YG = 3'd1,
        SEG_GC = 3'd2,
        SEG_CB = 3'd3,
        SEG_BM = 3'd4,
        SEG_MR = 3'd5
    } seg_e;

    localparam int RED   = 0;
    localparam int GREEN = 1;
    localparam int BLUE  = 2;

    function automatic seg_e seg_step(seg_e s, logic rev);
        if (rev) return (s == SEG_RY) ? SEG_MR : seg_e'(s - 3'd1);
        else     return (s == SEG_MR) ? SEG_RY : seg_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/color_sequencer_tick_gen.sv
// Tick prescaler: counts 0..c_TICK_CYCLES-1 and pulses tick on the terminal
// count; hold freezes the count and masks the tick.
module tick_gen #(
    parameter int c_TICK_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int CW = (c_TICK_CYCLES > 1) ? $clog2(c_TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(c_TICK_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = !hold && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// Hue-wheel sequencer producing registered R/G/B duty values for PWM stages.
// Define COLOR_SEQ_REVERSE_EN to add the dir input for reverse rotation.
//
// segment | meaning
// SEG_RY  | red full, green rising   (red -> yellow)
// SEG_YG  | green full, red falling  (yellow -> green)
// SEG_GC  | green full, blue rising  (green -> cyan)
// SEG_CB  | blue full, green falling (cyan -> blue)
// SEG_BM  | blue full, red rising    (blue -> magenta)
// SEG_MR  | red full, blue falling   (magenta -> red)
module color_sequencer
    import color_pkg::*;
#(
    parameter  int c_PWM_INTERVAL = 1200,
    parameter  int c_STEP         = 12,
    parameter  int c_TICK_CYCLES  = 20000,
    localparam int DW             = $clog2(c_PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
`ifdef COLOR_SEQ_REVERSE_EN
    input  logic          dir,
`endif
    output logic [DW-1:0] red_duty,
    output logic [DW-1:0] green_duty,
    output logic [DW-1:0] blue_duty,
    output logic          duty_strobe,
    output logic [2:0]    segment
);

    localparam logic [DW-1:0] MAX  = DW'(c_PWM_INTERVAL - 1);
    localparam logic [DW-1:0] STEP = DW'(c_STEP);

    logic          tick;
    logic          rev;
    logic          pending;
    seg_e          seg;
    logic [DW-1:0] ramp;
    logic [DW:0]   sum;
    logic [DW-1:0] up;
    logic [DW-1:0] dn;
    logic [DW-1:0] duty_next [3];

    tick_gen #(.c_TICK_CYCLES(c_TICK_CYCLES)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .hold (hold),
        .tick (tick)
    );

`ifdef COLOR_SEQ_REVERSE_EN
    assign rev = dir;
`else
    assign rev = 1'b0;
`endif

    // One extra bit so the forward sum cannot wrap before the clamp.
    assign sum     = {1'b0, ramp} + {1'b0, STEP};
    assign segment = seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg     <= SEG_RY;
            ramp    <= '0;
            pending <= 1'b0;
        end else begin
            pending <= tick && (seg <= SEG_MR);
            if (seg > SEG_MR) begin
                seg  <= SEG_RY;
                ramp <= '0;
            end else if (tick) begin
                if (!rev) begin
                    if (ramp == MAX) begin
                        ramp <= '0;
                        seg  <= seg_step(seg, 1'b0);
                    end else if (sum > {1'b0, MAX}) begin
                        ramp <= MAX;
                    end else begin
                        ramp <= sum[DW-1:0];
                    end
                end else begin
                    if (ramp == '0) begin
                        ramp <= MAX;
                        seg  <= seg_step(seg, 1'b1);
                    end else if (ramp < STEP) begin
                        ramp <= '0;
                    end else begin
                        ramp <= ramp - STEP;
                    end
                end
            end
        end
    end

    assign up = ramp;
    assign dn = MAX - ramp;

    always_comb begin
        duty_next[RED]   = MAX;
        duty_next[GREEN] = '0;
        duty_next[BLUE]  = '0;
        case (seg)
            SEG_RY: begin duty_next[RED] = MAX; duty_next[GREEN] = up;  end
            SEG_YG: begin duty_next[RED] = dn;  duty_next[GREEN] = MAX; end
            SEG_GC: begin duty_next[RED] = '0;  duty_next[GREEN] = MAX; duty_next[BLUE] = up;  end
            SEG_CB: begin duty_next[RED] = '0;  duty_next[GREEN] = dn;  duty_next[BLUE] = MAX; end
            SEG_BM: begin duty_next[RED] = up;  duty_next[BLUE]  = MAX; end
            SEG_MR: begin duty_next[RED] = MAX; duty_next[BLUE]  = dn;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_duty    <= MAX;
            green_duty  <= '0;
            blue_duty   <= '0;
            duty_strobe <= 1'b0;
        end else begin
            duty_strobe <= pending;
            if (pending) begin
                red_duty   <= duty_next[RED];
                green_duty <= duty_next[GREEN];
                blue_duty  <= duty_next[BLUE];
            end
        end
    end

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer with MAX=7, step 3, 4 clocks per tick.
module tb_color_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold = 1'b0;
`ifdef COLOR_SEQ_REVERSE_EN
    logic       dir = 1'b0;
`endif
    logic [2:0] red_duty;
    logic [2:0] green_duty;
    logic [2:0] blue_duty;
    logic       duty_strobe;
    logic [2:0] segment;

    int checks = 0;
    int errors = 0;

    // Each entry is octal {segment, R, G, B} seen at successive strobes.
    logic [11:0] exp_tab [24] = '{
        12'o0730, 12'o0760, 12'o0770, 12'o1770,
        12'o1470, 12'o1170, 12'o1070, 12'o2070,
        12'o2073, 12'o2076, 12'o2077, 12'o3077,
        12'o3047, 12'o3017, 12'o3007, 12'o4007,
        12'o4307, 12'o4607, 12'o4707, 12'o5707,
        12'o5704, 12'o5701, 12'o5700, 12'o0700
    };

    color_sequencer #(
        .c_PWM_INTERVAL (8),
        .c_STEP         (3),
        .c_TICK_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
`ifdef COLOR_SEQ_REVERSE_EN
        .dir         (dir),
`endif
        .red_duty    (red_duty),
        .green_duty  (green_duty),
        .blue_duty   (blue_duty),
        .duty_strobe (duty_strobe),
        .segment     (segment)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    function automatic logic [11:0] obs();
        return {segment, red_duty, green_duty, blue_duty};
    endfunction

    function automatic int step_ok(logic [11:0] a, logic [11:0] b);
        for (int k = 0; k < 3; k++) begin
            int x = int'(a[3*k +: 3]);
            int y = int'(b[3*k +: 3]);
            if (x - y > 3 || y - x > 3) return 0;
        end
        return 1;
    endfunction

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0o expected=%0o", tag, observed, expected);
        end
    endtask

    // Edges until duty_strobe is seen, sampled 1 ns after each edge.
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!duty_strobe && n < 20);
    endtask

    initial begin
        int n;
        int hs;
        logic [11:0] prev;
        logic [11:0] cur;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_duty", obs(), 12'o0700);
        chk("reset_strobe", duty_strobe, 0);
        rst  = 1'b0;
        prev = 12'o0700;

        // Release lands 1 ns after an edge: tick consumed on edge 4, duties on edge 5.
        for (int i = 0; i < 38; i++) begin
            wait_strobe(n);
            chk("strobe_latency", n, (i == 0) ? 5 : 4);
            cur = obs();
            chk("duty", cur, exp_tab[i % 24]);
            chk("step_limit", step_ok(prev, cur), 1);
            prev = cur;
            if (i == 8) begin
                // Count is 1 here; after release it needs 3 edges to tick and
                // one more for the registered duties, so latency stays 4.
                hold = 1'b1;
                hs   = 0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if (duty_strobe) hs++;
                end
                chk("hold_strobes", hs, 0);
                chk("hold_segment", segment, 2);
                chk("hold_duty", obs(), 12'o2073);
                hold = 1'b0;
            end
        end

        // Mid-seg3, strobe still high: reset between edges clears everything at once.
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_duty", obs(), 12'o0700);
        chk("async_reset_strobe", duty_strobe, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_strobe(n);
        chk("post_reset_latency", n, 5);
        chk("post_reset_duty", obs(), 12'o0730);
        @(posedge clk);
        #1;
        chk("strobe_width", duty_strobe, 0);

`ifdef COLOR_SEQ_REVERSE_EN
        rst = 1'b1;
        dir = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_strobe(n);
        chk("rev_latency", n, 5);
        chk("rev_first", obs(), 12'o5700);
        wait_strobe(n);
        chk("rev_second", obs(), 12'o5703);

        rst = 1'b1;
        dir = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_strobe(n);
        chk("fwd_first", obs(), 12'o0730);
        wait_strobe(n);
        chk("fwd_second", obs(), 12'o0760);
        dir = 1'b1;
        wait_strobe(n);
        chk("dir_flip_latency", n, 4);
        chk("dir_flip_duty", obs(), 12'o0730);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
